// File: rtl/fth_data_cp_pkg.sv
// Shared types and constants for the InBuf -> OutBuf packet copy engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fth_data_cp_pkg;

  localparam int AW_DEF   = 9;
  localparam int DW_DEF   = 32;
  localparam int PKT_SZ_W = 10;

  // Largest packet the 512-word buffers can hold, in 4-byte words.
  localparam logic [PKT_SZ_W-1:0] MAX_PKT_WD = 10'h200;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  // Oversized requests are clipped to the buffer depth rather than rejected.
  function automatic logic [PKT_SZ_W-1:0] clamp_pkt(input logic [PKT_SZ_W-1:0] sz);
    return (sz > MAX_PKT_WD) ? MAX_PKT_WD : sz;
  endfunction

endpackage

// File: rtl/fth_cpl_unit.sv
// Write-data transform: 2's complement with FTH_DATA_CP_CPL_EN defined, pass-through otherwise.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; follows its input every cycle.
module fth_cpl_unit
  import fth_data_cp_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

`ifdef FTH_DATA_CP_CPL_EN
  // Negation modulo 2^DW: 0 stays 0 and the most negative value maps onto itself.
  assign dout = ~din + DW'(1);
`else
  assign dout = din;
`endif

endmodule

// File: rtl/fth_data_cp.sv
// Copies N = min(size, 0x200) words InBuf[0..N-1] -> OutBuf[0..N-1]; data transform set by FTH_DATA_CP_CPL_EN.
// Latency: done pulse N+2 cycles after the start edge (1 cycle for N = 0); write trails read by 1 cycle.
// Backpressure: none; one word per cycle, starts while busy are dropped.
module fth_data_cp
  import fth_data_cp_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                iClk,
  input  logic                iRsn,
  input  logic                iStDtCp,
  input  logic [PKT_SZ_W-1:0] iPktWdSize,
  output logic                oDtCpDone,
  output logic                oBusy,
  output logic                oRdEn_InBuf,
  output logic [AW-1:0]       oRdAddr_InBuf,
  input  logic [DW-1:0]       iRdDt_InBuf,
  output logic                oWrEn_OutBuf,
  output logic [AW-1:0]       oWrAddr_OutBuf,
  output logic [DW-1:0]       oWrDt_OutBuf
);

  // Wide enough for both the packet size and a read address.
  localparam int CW = (AW > PKT_SZ_W) ? AW : PKT_SZ_W;

  state_t                state;
  logic [CW-1:0]         last_addr;
  logic [PKT_SZ_W-1:0]   n_clamp;
  logic                  done;
  logic                  busy;
  logic                  rd_en;
  logic                  wr_en;
  logic [AW-1:0]         rd_addr;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         cpl_dat;

  assign n_clamp = clamp_pkt(iPktWdSize);

  // Read data arrives one cycle after the read enable, i.e. in the same cycle as
  // the matching write, so the transform sits combinationally in the write path.
  fth_cpl_unit #(
    .DW (DW)
  ) u_cpl (
    .din  (iRdDt_InBuf),
    .dout (cpl_dat)
  );

  // Copy sequencer: fetch addresses, mirror them one cycle later as writes, then pulse done.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state     <= IDLE;
      last_addr <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
    end else begin
      // Write side is the read side delayed by one cycle; addresses hold when idle.
      wr_en <= rd_en;
      if (rd_en) begin
        wr_addr <= rd_addr;
      end
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (iStDtCp) begin
            busy <= 1'b1;
            if (n_clamp == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= FETCH;
              rd_en     <= 1'b1;
              rd_addr   <= '0;
              last_addr <= CW'(n_clamp) - CW'(1);
            end
          end
        end

        FETCH: begin
          // Stop on the last address instead of counting past it, so no wrap at 0x1FF.
          if (CW'(rd_addr) == last_addr) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end

        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          rd_en <= 1'b0;
        end
      endcase
    end
  end

  assign oDtCpDone      = done;
  assign oBusy          = busy;
  assign oRdEn_InBuf    = rd_en;
  assign oRdAddr_InBuf  = rd_addr;
  assign oWrEn_OutBuf   = wr_en;
  assign oWrAddr_OutBuf = wr_addr;
  // Gated so the data bus reads 0 whenever no write is in flight, including in reset.
  assign oWrDt_OutBuf   = wr_en ? cpl_dat : '0;

endmodule

// File: tb/tb_fth_data_cp.sv
// Directed bench for fth_data_cp with behavioural InBuf/OutBuf memories.
// Latency: n/a.
// Backpressure: n/a.
module tb_fth_data_cp;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          iClk = 1'b0;
  logic          iRsn = 1'b0;
  logic          iStDtCp = 1'b0;
  logic [9:0]    iPktWdSize = '0;
  logic          oDtCpDone;
  logic          oBusy;
  logic          oRdEn_InBuf;
  logic [AW-1:0] oRdAddr_InBuf;
  logic [DW-1:0] iRdDt_InBuf = '0;
  logic          oWrEn_OutBuf;
  logic [AW-1:0] oWrAddr_OutBuf;
  logic [DW-1:0] oWrDt_OutBuf;

  logic [31:0] inbuf  [512];
  logic [31:0] outbuf [512];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [9:0]        size;
    int                pat;
    int                exp_n;
    int                exp_done;
    int                n_hand;
    logic [3:0][31:0]  exp_w;
  } vec_t;

  vec_t vecs [8];

  fth_data_cp #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .iClk           (iClk),
    .iRsn           (iRsn),
    .iStDtCp        (iStDtCp),
    .iPktWdSize     (iPktWdSize),
    .oDtCpDone      (oDtCpDone),
    .oBusy          (oBusy),
    .oRdEn_InBuf    (oRdEn_InBuf),
    .oRdAddr_InBuf  (oRdAddr_InBuf),
    .iRdDt_InBuf    (iRdDt_InBuf),
    .oWrEn_OutBuf   (oWrEn_OutBuf),
    .oWrAddr_OutBuf (oWrAddr_OutBuf),
    .oWrDt_OutBuf   (oWrDt_OutBuf)
  );

  always #5 iClk = ~iClk;

  // InBuf: read data valid one cycle after the enable
  always @(posedge iClk) if (oRdEn_InBuf) iRdDt_InBuf <= inbuf[oRdAddr_InBuf];

  // OutBuf: write on enable
  always @(posedge iClk) if (oWrEn_OutBuf) outbuf[oWrAddr_OutBuf] <= oWrDt_OutBuf;

  function automatic logic [31:0] exp_dat(input logic [31:0] x);
`ifdef FTH_DATA_CP_CPL_EN
    return ~x + 32'd1;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic fill(input int pat, input logic [31:0] seed);
    for (int i = 0; i < 512; i++) inbuf[i] = seed ^ (32'(i) * 32'h9E3779B1);
    if (pat == 1) begin
      inbuf[0] = 32'h0000_0001;
      inbuf[1] = 32'h0000_0000;
      inbuf[2] = 32'h8000_0000;
      inbuf[3] = 32'hFFFF_FFFF;
    end else if (pat == 2) begin
      inbuf[0] = 32'h0000_0005;
      inbuf[1] = 32'h0000_000A;
    end
  endtask

  function automatic logic outs_zero();
    return ({oDtCpDone, oBusy, oRdEn_InBuf, oWrEn_OutBuf,
             oRdAddr_InBuf, oWrAddr_OutBuf, oWrDt_OutBuf} == '0);
  endfunction

  // Start a copy and watch it for 'limit' cycles; cycle k = value seen k edges after the start edge's cycle.
  task automatic run_copy(input logic [9:0] size, input int repulse_cyc, input int rst_cyc,
                          input int limit,
                          output int done_cyc, output int ndone, output int nrd, output int nwr,
                          output int busy_cyc, output int addr_err, output int data_err,
                          output int rst_err);
    logic          prev_rd;
    logic [AW-1:0] prev_rd_addr;
    done_cyc = -1; ndone = 0; nrd = 0; nwr = 0; busy_cyc = 0;
    addr_err = 0; data_err = 0; rst_err = 0;
    prev_rd = 1'b0; prev_rd_addr = '0;
    @(negedge iClk);
    iStDtCp    = 1'b1;
    iPktWdSize = size;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge iClk);
      iStDtCp = (cyc == repulse_cyc);
      if (cyc == repulse_cyc) iPktWdSize = 10'd2;
      if (cyc == rst_cyc) begin
        iRsn = 1'b0;
        #1;
      end
      if (rst_cyc > 0 && cyc == rst_cyc + 2) iRsn = 1'b1;
      if (rst_cyc > 0 && cyc >= rst_cyc && cyc <= rst_cyc + 2) begin
        if (!outs_zero()) rst_err++;
        prev_rd = 1'b0;
      end else begin
        if (oDtCpDone) begin
          ndone++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (oBusy) busy_cyc++;
        if (oRdEn_InBuf) begin
          if (oRdAddr_InBuf != AW'(nrd)) addr_err++;
          nrd++;
        end
        if (oWrEn_OutBuf) begin
          if (oWrAddr_OutBuf != AW'(nwr)) addr_err++;
          nwr++;
        end
        if (oWrEn_OutBuf != prev_rd) addr_err++;
        if (oWrEn_OutBuf && oWrAddr_OutBuf != prev_rd_addr) addr_err++;
        prev_rd      = oRdEn_InBuf;
        prev_rd_addr = oRdAddr_InBuf;
      end
    end
    iStDtCp = 1'b0;
    for (int i = 0; i < nwr && i < 512; i++)
      if (outbuf[i] !== exp_dat(inbuf[i])) data_err++;
  endtask

  initial begin
    int dc, nd, nr, nw, bc, ae, de, re;

    vecs[0] = '{10'd4,     1, 4,   6,   4, 128'h0};
    vecs[1] = '{10'd0,     0, 0,   1,   0, 128'h0};
    vecs[2] = '{10'd1,     0, 1,   3,   0, 128'h0};
    vecs[3] = '{10'd2,     2, 2,   4,   2, 128'h0};
    vecs[4] = '{10'd7,     0, 7,   9,   0, 128'h0};
    vecs[5] = '{10'h200,   0, 512, 514, 0, 128'h0};
    vecs[6] = '{10'h201,   0, 512, 514, 0, 128'h0};
    vecs[7] = '{10'h3FF,   0, 512, 514, 0, 128'h0};
`ifdef FTH_DATA_CP_CPL_EN
    vecs[0].exp_w = {32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[3].exp_w = {32'h0, 32'h0, 32'hFFFF_FFF6, 32'hFFFF_FFFB};
`else
    vecs[0].exp_w = {32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001};
    vecs[3].exp_w = {32'h0, 32'h0, 32'h0000_000A, 32'h0000_0005};
`endif

    // Reset state
    #2;
    chk("rst_outputs_zero", 64'(outs_zero()), 64'd1);
    repeat (2) @(negedge iClk);
    iRsn = 1'b1;
    repeat (2) @(negedge iClk);
    chk("idle_outputs_zero", 64'(outs_zero()), 64'd1);

    // Table-driven copies
    for (int i = 0; i < 8; i++) begin
      fill(vecs[i].pat, 32'hC0DE_0000 + 32'(i));
      run_copy(vecs[i].size, 0, 0, vecs[i].exp_done + 3, dc, nd, nr, nw, bc, ae, de, re);
      chk($sformatf("v%0d_done_cyc", i), 64'(dc), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_done_cnt", i), 64'(nd), 64'd1);
      chk($sformatf("v%0d_reads", i),    64'(nr), 64'(vecs[i].exp_n));
      chk($sformatf("v%0d_writes", i),   64'(nw), 64'(vecs[i].exp_n));
      chk($sformatf("v%0d_busy_cyc", i), 64'(bc), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_addr_err", i), 64'(ae), 64'd0);
      chk($sformatf("v%0d_data_err", i), 64'(de), 64'd0);
      chk($sformatf("v%0d_idle_after", i),
          64'({oBusy, oRdEn_InBuf, oWrEn_OutBuf, oDtCpDone, oWrDt_OutBuf}), 64'd0);
      if (vecs[i].exp_n > 0) begin
        chk($sformatf("v%0d_rd_addr_hold", i), 64'(oRdAddr_InBuf), 64'(vecs[i].exp_n - 1));
        chk($sformatf("v%0d_wr_addr_hold", i), 64'(oWrAddr_OutBuf), 64'(vecs[i].exp_n - 1));
      end
      for (int k = 0; k < 4; k++)
        if (k < vecs[i].n_hand)
          chk($sformatf("v%0d_word%0d", i, k), 64'(outbuf[k]), 64'(vecs[i].exp_w[k]));
    end

    // Re-pulsed start and size change mid-copy are ignored
    fill(0, 32'h5A5A_0000);
    run_copy(10'd8, 3, 0, 14, dc, nd, nr, nw, bc, ae, de, re);
    chk("restart_done_cyc", 64'(dc), 64'd10);
    chk("restart_done_cnt", 64'(nd), 64'd1);
    chk("restart_writes",   64'(nw), 64'd8);
    chk("restart_addr_err", 64'(ae), 64'd0);
    chk("restart_data_err", 64'(de), 64'd0);

    // Reset mid-copy aborts with no done pulse; earlier writes stay in OutBuf
    fill(0, 32'h1234_0000);
    run_copy(10'd16, 0, 5, 20, dc, nd, nr, nw, bc, ae, de, re);
    chk("midrst_outputs_zero", 64'(re), 64'd0);
    chk("midrst_done_cnt",     64'(nd), 64'd0);
    chk("midrst_reads",        64'(nr), 64'd4);
    chk("midrst_writes",       64'(nw), 64'd3);
    chk("midrst_busy_cyc",     64'(bc), 64'd4);
    chk("midrst_addr_err",     64'(ae), 64'd0);
    chk("midrst_data_err",     64'(de), 64'd0);

    // Fresh copy after reset release
    fill(2, 32'h0F0F_0000);
    run_copy(10'd2, 0, 0, 6, dc, nd, nr, nw, bc, ae, de, re);
    chk("post_rst_done_cyc", 64'(dc), 64'd4);
    chk("post_rst_done_cnt", 64'(nd), 64'd1);
    chk("post_rst_writes",   64'(nw), 64'd2);
    chk("post_rst_addr_err", 64'(ae), 64'd0);
    chk("post_rst_word0",    64'(outbuf[0]), 64'(vecs[3].exp_w[0]));
    chk("post_rst_word1",    64'(outbuf[1]), 64'(vecs[3].exp_w[1]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fth_data_cp.md
FTH_DATA_CP -- requirements
Module: fth_data_cp

Interface
REQ-001 SHALL have parameter AW, default 9, meaning the word-address width of InBuf and OutBuf (512-word depth).
REQ-002 SHALL have parameter DW, default 32, meaning the data word width.
REQ-003 SHALL have port iClk, input, 1, the single clock, rising edge.
REQ-004 SHALL have port iRsn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port iStDtCp, input, 1, 1-clock start pulse from the APB interface block.
REQ-006 SHALL have port iPktWdSize, input, 10, packet size in 4-byte words, legal range 0..0x200.
REQ-007 SHALL have port oDtCpDone, output, 1, 1-clock completion pulse.
REQ-008 SHALL have port oBusy, output, 1, high while a copy is in progress.
REQ-009 SHALL have port oRdEn_InBuf, output, 1, InBuf read enable.
REQ-010 SHALL have port oRdAddr_InBuf, output, AW, InBuf word read address.
REQ-011 SHALL have port iRdDt_InBuf, input, DW, InBuf read data, valid exactly 1 cycle after oRdEn_InBuf.
REQ-012 SHALL have port oWrEn_OutBuf, output, 1, OutBuf write enable.
REQ-013 SHALL have port oWrAddr_OutBuf, output, AW, OutBuf word write address.
REQ-014 SHALL have port oWrDt_OutBuf, output, DW, OutBuf write data.

Function
REQ-015 SHALL implement the FSM states IDLE, FETCH, DRAIN and DONE.
REQ-016 In IDLE, iStDtCp high at a rising edge SHALL latch N = min(iPktWdSize, 0x200) and enter FETCH, or enter DONE directly if N = 0.
REQ-017 In FETCH, oRdEn_InBuf SHALL be high for exactly N consecutive cycles with oRdAddr_InBuf = 0, 1, ..., N-1, followed by entry to DRAIN.
REQ-018 Each read SHALL produce one write exactly 1 cycle later, with oWrAddr_OutBuf equal to the read address delayed 1 cycle and oWrEn_OutBuf high for N consecutive cycles.
REQ-019 oWrDt_OutBuf SHALL equal (~iRdDt_InBuf + 1) mod 2^DW; input 0 SHALL give 0 and 0x80000000 SHALL give 0x80000000.
REQ-020 DRAIN SHALL last 1 cycle (the last write) and then enter DONE.
REQ-021 DONE SHALL last 1 cycle with oDtCpDone = 1 and then return to IDLE; oDtCpDone SHALL be high N+2 cycles after the start edge for N > 0, and 1 cycle after it for N = 0.
REQ-022 oBusy SHALL be high in FETCH, DRAIN and DONE, and low in IDLE.
REQ-023 iStDtCp outside IDLE SHALL be ignored: no restart, no queuing.
REQ-024 Changes to iPktWdSize after the start edge SHALL NOT affect the copy in progress.
REQ-025 Read and write address counters SHALL never wrap; N = 0x200 SHALL end at address 0x1FF.
REQ-026 oRdAddr_InBuf and oWrAddr_OutBuf SHALL hold their last value when their enable is low.

Reset
REQ-027 iRsn low SHALL immediately force IDLE and drive oDtCpDone, oBusy, oRdEn_InBuf and oWrEn_OutBuf to 0 and all addresses and oWrDt_OutBuf to 0.
REQ-028 Reset asserted mid-copy SHALL abort the copy with no done pulse; any partially written OutBuf contents SHALL be left as is.
REQ-029 After reset release, the first start SHALL behave as a fresh copy.

Configuration
REQ-030 With the macro FTH_DATA_CP_CPL_EN defined, the write data SHALL be the 2's complement per REQ-019.
REQ-031 Without FTH_DATA_CP_CPL_EN, oWrDt_OutBuf SHALL equal iRdDt_InBuf unchanged, with identical timing.

Structure
REQ-032 Package fth_data_cp_pkg SHALL hold the FSM state typedef, the AW/DW defaults and the constant MAX_PKT_WD = 0x200.
REQ-033 The complement datapath SHALL be a combinational sub-module, fth_cpl_unit, whose function is selected by FTH_DATA_CP_CPL_EN.

Verification
REQ-034 Scenario: size 4, InBuf[0..3] = 1, 0, 0x80000000, 0xFFFFFFFF, start -> OutBuf[0..3] = 0xFFFFFFFF, 0, 0x80000000, 1; done pulse at cycle 6.
REQ-035 Scenario: size 0, start -> no read or write enable; done pulse 1 cycle after start; oBusy high for 1 cycle.
REQ-036 Scenario: size 0x3FF, start -> exactly 512 reads and writes, last address 0x1FF, done pulse at cycle 514.
REQ-037 Scenario: start a size-8 copy, re-pulse iStDtCp at cycle 3 and change iPktWdSize to 2 -> still 8 writes and a single done pulse.
REQ-038 Scenario: size 16 copy, iRsn low at cycle 5 -> all outputs 0 immediately, no done pulse; a later size-2 start completes normally.
REQ-039 Scenario: build without FTH_DATA_CP_CPL_EN, size 2, InBuf = 5, 0xA -> OutBuf = 5, 0xA.
